capture_dump: RTL and testbench
===============================

// Module: capture_dump
// PURPOSE
//  Read-back sequencer for the capture RAMs. After a capture completes, the command
//  path requests a dump of one channel. This block then walks the circular sample
//  buffer from the oldest sample to the newest. Each byte goes to the UART
//  transmitter with a start/done handshake. When the dump is finished, the block
//  pulses clr_capture_done so the capture unit can re-arm.
// PARAMETERS
//  ENTRIES  384  samples per channel RAM (12288 on DE-0)
//  LOG2     9    address width, ceil(log2(ENTRIES))
//  NUM_CH   5    number of channel RAMs, each 8 bits wide
// PORTS
//  clk               in   1           system clock
//  rst               in   1           synchronous active-high reset
//  dump_start        in   1           one-cycle request from cmd_cfg
//  ch_sel            in   3           channel to dump; latched at dump_start
//  waddr_end         in   LOG2        capture write pointer = oldest sample address
//  rdata             in   8*NUM_CH    RAM read data; channel k is rdata[8k+7:8k]
//  tx_done           in   1           UART finished the current byte (1-cycle pulse)
//  ren               out  1           RAM read enable
//  raddr             out  LOG2        RAM read address
//  tx_start          out  1           one-cycle pulse; tx_data is valid in that cycle
//  tx_data           out  8           byte to transmit
//  busy              out  1           high in every state except IDLE
//  dump_done         out  1           one-cycle pulse at end of dump
//  clr_capture_done  out  1           one-cycle pulse, same cycle as dump_done
//  dump_err          out  1           one-cycle pulse when a request is rejected
// BEHAVIOUR
//  - Interface: one clock; reset is synchronous and active-high.
//  - Reset: state=IDLE. All outputs are 0. Internal addr, cnt and ch registers are 0.
//  - States: IDLE, READ, LAT, SEND, WAIT_TX, DONE.
//  - IDLE:
//    - dump_start=1 with ch_sel<NUM_CH: latch ch=ch_sel and cnt=0. Set addr=waddr_end,
//      or addr=0 if waddr_end>=ENTRIES. Go to READ.
//    - dump_start=1 with ch_sel>=NUM_CH: pulse dump_err next cycle and stay in IDLE.
//  - READ: ren=1, raddr=addr. Go to LAT. The RAM has a 1-cycle registered read.
//  - LAT: tx_data <= rdata[8*ch +: 8]. Go to SEND.
//  - SEND: tx_start=1 for exactly one cycle; tx_data is held. Go to WAIT_TX.
//  - WAIT_TX: hold until tx_done=1. A tx_done that arrives in any other state is ignored.
//    - On tx_done with cnt==ENTRIES-1: go to DONE.
//    - Otherwise: cnt<=cnt+1, addr<=(addr==ENTRIES-1)?0:addr+1, go to READ.
//  - DONE: dump_done=1 and clr_capture_done=1 for one cycle, then go to IDLE.
//  - Totals: exactly ENTRIES bytes are sent. Address order is waddr_end,...,ENTRIES-1,0,...,waddr_end-1.
//  - Latency: dump_start at cycle N gives ren at N+1 and the first tx_start at N+3.
//    Each later byte gives tx_start 3 cycles after the tx_done of the previous byte.
//  - dump_start while busy is ignored, with no dump_err. ch_sel and waddr_end are
//    only sampled in IDLE.
//  - tx_data holds its last value between bytes and after the dump.
//  - raddr holds its value when ren=0.
//  - rst asserted mid-dump: go to IDLE on the next edge and apply all reset values.
//    No dump_done or clr_capture_done pulse is produced.
//  - Arithmetic: cnt and addr are LOG2 bits wide. The wrap compare is against
//    ENTRIES-1, not 2^LOG2-1.
// TESTING
//  - Run with ENTRIES=384 throughout. The UART model returns tx_done 4 cycles after tx_start.
//  - waddr_end=0, ch_sel=2, RAM[i]=i[7:0] -> 384 bytes, 0x00..0xFF then 0x00..0x7F.
//    Then a single dump_done/clr_capture_done pulse.
//  - waddr_end=383 -> raddr sequence 383,0,1,...,382; the first byte is RAM[383].
//  - waddr_end=100, ch_sel=4 -> first raddr=100, wrap 383->0, last raddr=99.
//    Only the ch4 byte lane appears on tx_data.
//  - ch_sel=5 -> dump_err pulses once, busy stays 0, no ren or tx_start.
//  - dump_start re-pulsed mid-dump -> ignored; the byte count is still 384.
//  - rst at byte 10 -> all outputs 0 next cycle, no clr_capture_done.
//    A new dump_start then restarts cleanly from waddr_end.
//  - tx_done asserted in READ or LAT -> ignored; the sequence is unchanged.

Source files
------------

// File: rtl/capture_dump.sv
// Read-back sequencer for the capture RAMs: walks one channel's circular buffer from oldest to
// newest sample and hands each byte to the UART transmitter, then re-arms the capture unit.
module capture_dump #(
   parameter int unsigned ENTRIES = 384,
   parameter int unsigned LOG2    = 9,
   parameter int unsigned NUM_CH  = 5
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                dump_start,
   input  logic [2:0]          ch_sel,
   input  logic [LOG2-1:0]     waddr_end,
   input  logic [8*NUM_CH-1:0] rdata,
   input  logic                tx_done,
   output logic                ren,
   output logic [LOG2-1:0]     raddr,
   output logic                tx_start,
   output logic [7:0]          tx_data,
   output logic                busy,
   output logic                dump_done,
   output logic                clr_capture_done,
   output logic                dump_err
);

   typedef enum logic [2:0] {
      StIdle,
      StRead,
      StLat,
      StSend,
      StWaitTx,
      StDone
   } state_e;

   // Wrap point is the last real entry, not the top of the address space.
   localparam logic [LOG2-1:0] LastAddr = LOG2'(ENTRIES - 1);

   state_e          state_q, state_d;
   logic [LOG2-1:0] addr_q, addr_d;
   logic [LOG2-1:0] cnt_q, cnt_d;
   logic [2:0]      ch_q, ch_d;
   logic [7:0]      tx_data_q, tx_data_d;
   logic            dump_err_q, dump_err_d;
   logic [7:0]      lane;
   logic            ch_ok;
   logic            waddr_ok;

   assign ch_ok    = 32'(ch_sel) < NUM_CH;
   assign waddr_ok = 32'(waddr_end) < ENTRIES;

   always_comb begin
      lane = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (32'(ch_q) == k) begin
            lane = rdata[8*k +: 8];
         end
      end
   end

   always_comb begin
      state_d          = state_q;
      addr_d           = addr_q;
      cnt_d            = cnt_q;
      ch_d             = ch_q;
      tx_data_d        = tx_data_q;
      dump_err_d       = 1'b0;
      ren              = 1'b0;
      tx_start         = 1'b0;
      dump_done        = 1'b0;
      clr_capture_done = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (dump_start) begin
               if (ch_ok) begin
                  ch_d    = ch_sel;
                  cnt_d   = '0;
                  addr_d  = waddr_ok ? waddr_end : '0;
                  state_d = StRead;
               end else begin
                  dump_err_d = 1'b1;
               end
            end
         end
         StRead: begin
            ren     = 1'b1;
            state_d = StLat;
         end
         StLat: begin
            // RAM data for the address presented in StRead is valid now.
            tx_data_d = lane;
            state_d   = StSend;
         end
         StSend: begin
            tx_start = 1'b1;
            state_d  = StWaitTx;
         end
         StWaitTx: begin
            if (tx_done) begin
               if (cnt_q == LastAddr) begin
                  state_d = StDone;
               end else begin
                  cnt_d   = cnt_q + LOG2'(1);
                  addr_d  = (addr_q == LastAddr) ? '0 : addr_q + LOG2'(1);
                  state_d = StRead;
               end
            end
         end
         StDone: begin
            dump_done        = 1'b1;
            clr_capture_done = 1'b1;
            state_d          = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         addr_q     <= '0;
         cnt_q      <= '0;
         ch_q       <= '0;
         tx_data_q  <= '0;
         dump_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         cnt_q      <= cnt_d;
         ch_q       <= ch_d;
         tx_data_q  <= tx_data_d;
         dump_err_q <= dump_err_d;
      end
   end

   assign raddr    = addr_q;
   assign tx_data  = tx_data_q;
   assign busy     = (state_q != StIdle);
   assign dump_err = dump_err_q;

endmodule

// File: tb/tb_capture_dump.sv
// Randomized bench for capture_dump: RAM and UART models plus a reference of the expected
// circular read order, byte stream and handshake timing.
module tb_capture_dump;

   localparam int unsigned ENTRIES = 384;
   localparam int unsigned LOG2    = 9;
   localparam int unsigned NUM_CH  = 5;
   localparam int          TxLat   = 4;
   localparam int          ByteGap = TxLat + 3;

   logic                clk        = 1'b0;
   logic                rst        = 1'b1;
   logic                dump_start = 1'b0;
   logic                tx_done    = 1'b0;
   logic [2:0]          ch_sel     = '0;
   logic [LOG2-1:0]     waddr_end  = '0;
   logic [8*NUM_CH-1:0] rdata      = '0;
   logic                ren;
   logic [LOG2-1:0]     raddr;
   logic                tx_start;
   logic [7:0]          tx_data;
   logic                busy;
   logic                dump_done;
   logic                clr_capture_done;
   logic                dump_err;

   always #5 clk = ~clk;

   capture_dump #(
      .ENTRIES(ENTRIES),
      .LOG2   (LOG2),
      .NUM_CH (NUM_CH)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .dump_start      (dump_start),
      .ch_sel          (ch_sel),
      .waddr_end       (waddr_end),
      .rdata           (rdata),
      .tx_done         (tx_done),
      .ren             (ren),
      .raddr           (raddr),
      .tx_start        (tx_start),
      .tx_data         (tx_data),
      .busy            (busy),
      .dump_done       (dump_done),
      .clr_capture_done(clr_capture_done),
      .dump_err        (dump_err)
   );

   // Registered-read RAM model, all channels read in parallel.
   logic [7:0] ram [NUM_CH][ENTRIES];
   always @(posedge clk) begin
      if (ren) begin
         for (int k = 0; k < NUM_CH; k++) rdata[8*k +: 8] <= ram[k][raddr];
      end
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // Observation log, cleared before each dump.
   logic [7:0]      byte_log[$];
   logic [LOG2-1:0] raddr_log[$];
   int first_ren_cyc, first_start_cyc, last_start_cyc, done_cyc, err_cyc;
   int gap_bad, done_cnt, clr_cnt, pair_bad, err_cnt, busy_cnt;
   bit spur_en = 1'b0;

   function automatic void clear_mon();
      byte_log.delete();
      raddr_log.delete();
      first_ren_cyc   = -1;
      first_start_cyc = -1;
      last_start_cyc  = -1;
      done_cyc        = -1;
      err_cyc         = -1;
      gap_bad         = 0;
      done_cnt        = 0;
      clr_cnt         = 0;
      pair_bad        = 0;
      err_cnt         = 0;
      busy_cnt        = 0;
   endfunction

   function automatic logic [63:0] qb(input int i);
      if (i < byte_log.size()) return 64'(byte_log[i]);
      return '1;
   endfunction

   function automatic logic [63:0] qa(input int i);
      if (i < raddr_log.size()) return 64'(raddr_log[i]);
      return '1;
   endfunction

   initial begin
      clear_mon();
      forever begin
         @(negedge clk);
         if (ren) begin
            raddr_log.push_back(raddr);
            if (first_ren_cyc < 0) first_ren_cyc = cyc;
         end
         if (tx_start) begin
            byte_log.push_back(tx_data);
            if (last_start_cyc >= 0 && cyc - last_start_cyc != ByteGap) gap_bad++;
            if (first_start_cyc < 0) first_start_cyc = cyc;
            last_start_cyc = cyc;
         end
         if (dump_done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (clr_capture_done) clr_cnt++;
         if (dump_done != clr_capture_done) pair_bad++;
         if (dump_err) begin
            err_cnt++;
            err_cyc = cyc;
         end
         if (busy) busy_cnt++;
      end
   end

   // UART model: tx_done one cycle wide, TxLat cycles after tx_start; optional stray
   // tx_done pulses while the DUT is in its read and latch cycles.
   initial begin
      int   pend;
      logic ren_prev;
      pend     = 0;
      ren_prev = 1'b0;
      forever begin
         @(negedge clk);
         tx_done = 1'b0;
         if (pend > 0) begin
            pend--;
            if (pend == 0) tx_done = 1'b1;
         end
         if (tx_start) pend = TxLat;
         if (spur_en && (ren || ren_prev)) tx_done = 1'b1;
         ren_prev = ren;
      end
   end

   task automatic fill_ram(input bit ramp);
      for (int k = 0; k < NUM_CH; k++) begin
         for (int i = 0; i < ENTRIES; i++) ram[k][i] = 8'($urandom);
      end
      if (ramp) begin
         for (int i = 0; i < ENTRIES; i++) ram[2][i] = 8'(i);
      end
   endtask

   task automatic check_idle_outputs(input string name);
      check_eq({name, " ren"}, ren, 0);
      check_eq({name, " raddr"}, raddr, 0);
      check_eq({name, " tx_start"}, tx_start, 0);
      check_eq({name, " tx_data"}, tx_data, 0);
      check_eq({name, " busy"}, busy, 0);
      check_eq({name, " dump_done"}, dump_done, 0);
      check_eq({name, " clr_done"}, clr_capture_done, 0);
      check_eq({name, " dump_err"}, dump_err, 0);
   endtask

   task automatic do_dump(input logic [2:0] ch, input logic [LOG2-1:0] w, input int repulse_at,
                          input string name);
      int start_at, k, w0, mism_b, mism_a;
      clear_mon();
      @(negedge clk);
      ch_sel     = ch;
      waddr_end  = w;
      dump_start = 1'b1;
      start_at   = cyc;
      @(negedge clk);
      dump_start = 1'b0;
      k = 0;
      while (done_cnt == 0 && k < ENTRIES * ByteGap + 50) begin
         @(negedge clk);
         k++;
         if (k == repulse_at) begin
            dump_start = 1'b1;
            ch_sel     = 3'($urandom_range(0, NUM_CH - 1));
            waddr_end  = LOG2'($urandom);
         end else begin
            dump_start = 1'b0;
         end
      end
      dump_start = 1'b0;
      repeat (4) @(negedge clk);

      w0 = (int'(w) >= ENTRIES) ? 0 : int'(w);
      mism_b = 0;
      mism_a = 0;
      for (int i = 0; i < ENTRIES; i++) begin
         int a;
         a = (w0 + i) % ENTRIES;
         if (qb(i) !== 64'(ram[ch][a])) mism_b++;
         if (qa(i) !== 64'(a)) mism_a++;
      end
      check_eq({name, " byte count"}, byte_log.size(), ENTRIES);
      check_eq({name, " read count"}, raddr_log.size(), ENTRIES);
      check_eq({name, " byte mismatches"}, mism_b, 0);
      check_eq({name, " addr mismatches"}, mism_a, 0);
      check_eq({name, " ren latency"}, first_ren_cyc - start_at, 1);
      check_eq({name, " tx latency"}, first_start_cyc - start_at, 3);
      check_eq({name, " byte gaps"}, gap_bad, 0);
      check_eq({name, " done pulses"}, done_cnt, 1);
      check_eq({name, " clr pulses"}, clr_cnt, 1);
      check_eq({name, " done/clr pairing"}, pair_bad, 0);
      check_eq({name, " done latency"}, done_cyc - last_start_cyc, TxLat + 1);
      check_eq({name, " busy cycles"}, busy_cnt, done_cyc - start_at);
      check_eq({name, " dump_err"}, err_cnt, 0);
      check_eq({name, " tx_data hold"}, tx_data, ram[ch][(w0 + ENTRIES - 1) % ENTRIES]);
      check_eq({name, " idle after"}, busy, 0);
   endtask

   initial begin
      int k;
      int start_at;
      logic [2:0] ch;

      // Reset state
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check_idle_outputs("reset");
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Ramp on channel 2, oldest sample at address 0
      fill_ram(1'b1);
      do_dump(3'd2, 9'd0, -1, "ramp");
      check_eq("ramp byte 0", qb(0), 8'h00);
      check_eq("ramp byte 255", qb(255), 8'hFF);
      check_eq("ramp byte 256", qb(256), 8'h00);
      check_eq("ramp last byte", qb(383), 8'h7F);

      // Oldest sample at the last entry
      fill_ram(1'b0);
      ch = 3'($urandom_range(0, NUM_CH - 1));
      do_dump(ch, 9'd383, -1, "w383");
      check_eq("w383 first raddr", qa(0), 383);
      check_eq("w383 second raddr", qa(1), 0);
      check_eq("w383 last raddr", qa(383), 382);
      check_eq("w383 first byte", qb(0), ram[ch][383]);

      // Mid-buffer start on the highest channel
      do_dump(3'd4, 9'd100, -1, "w100");
      check_eq("w100 first raddr", qa(0), 100);
      check_eq("w100 wrap top", qa(283), 383);
      check_eq("w100 wrap zero", qa(284), 0);
      check_eq("w100 last raddr", qa(383), 99);

      // Invalid channels are rejected
      for (int c = NUM_CH; c < 8; c++) begin
         clear_mon();
         @(negedge clk);
         ch_sel     = 3'(c);
         dump_start = 1'b1;
         start_at   = cyc;
         @(negedge clk);
         dump_start = 1'b0;
         repeat (6) @(negedge clk);
         check_eq("bad ch err pulses", err_cnt, 1);
         check_eq("bad ch err latency", err_cyc - start_at, 1);
         check_eq("bad ch busy", busy_cnt, 0);
         check_eq("bad ch reads", raddr_log.size(), 0);
         check_eq("bad ch bytes", byte_log.size(), 0);
      end

      // dump_start re-pulsed with different ch_sel/waddr_end mid-dump
      fill_ram(1'b0);
      do_dump(3'd3, 9'd200, 50, "repulse");

      // Reset partway through a dump, then a clean restart
      clear_mon();
      @(negedge clk);
      ch_sel     = 3'd1;
      waddr_end  = 9'd50;
      dump_start = 1'b1;
      @(negedge clk);
      dump_start = 1'b0;
      k = 0;
      while (byte_log.size() < 10 && k < 200) begin
         @(negedge clk);
         k++;
      end
      check_eq("midrst reached byte 10", byte_log.size() >= 10, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_idle_outputs("midrst");
      repeat (30) @(negedge clk);
      check_eq("midrst no done", done_cnt, 0);
      check_eq("midrst no clr", clr_cnt, 0);
      do_dump(3'd1, 9'd50, -1, "restart");

      // Stray tx_done pulses during read/latch cycles
      spur_en = 1'b1;
      do_dump(3'd0, 9'd17, -1, "spurious");
      spur_en = 1'b0;

      // Out-of-range oldest pointer falls back to address 0
      fill_ram(1'b0);
      do_dump(3'($urandom_range(0, NUM_CH - 1)), 9'd400, -1, "w400");
      do_dump(3'($urandom_range(0, NUM_CH - 1)), 9'd511, -1, "w511");

      // Random pointers and channels
      for (int r = 0; r < 2; r++) begin
         fill_ram(1'b0);
         do_dump(3'($urandom_range(0, NUM_CH - 1)), LOG2'($urandom_range(0, ENTRIES - 1)), -1,
                 "random");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
